// File: rtl/nor_chk_pkg.sv
// Shared types and constants for the NOR logic-unit self-test checker.
package nor_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Function codes of the unit under test, indexed by sel
    localparam logic [2:0] FN_NOT_A    = 3'd0;
    localparam logic [2:0] FN_NOR      = 3'd1;
    localparam logic [2:0] FN_AND      = 3'd2;
    localparam logic [2:0] FN_OR       = 3'd3;
    localparam logic [2:0] FN_XOR      = 3'd4;
    localparam logic [2:0] FN_XNOR     = 3'd5;
    localparam logic [2:0] FN_NAND     = 3'd6;
    localparam logic [2:0] FN_NAND_ALT = 3'd7;

    localparam int VEC_W = 5;
    localparam int CNT_W = 6;

    localparam logic [VEC_W-1:0] VEC_LAST = 5'd31;

endpackage

// File: rtl/nor_func_checker_if.sv
// Signal bundle between the checker (master) and the board/bench side (slave).
interface nor_func_checker_if;
    import nor_chk_pkg::*;

    logic             start;
    logic             dut_out;
    logic             dut_a;
    logic             dut_b;
    logic [2:0]       dut_sel;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [VEC_W-1:0] first_fail;

    modport master (
        input  start, dut_out,
        output dut_a, dut_b, dut_sel, busy, done, pass, err_cnt, first_fail
    );

    modport slave (
        output start, dut_out,
        input  dut_a, dut_b, dut_sel, busy, done, pass, err_cnt, first_fail
    );

endinterface

// File: rtl/nor_chk_golden.sv
// Golden reference for the 8-function NOR logic unit: {sel,a,b} -> expected out.
module nor_chk_golden
    import nor_chk_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    // Reference truth function per select code
    always_comb begin
        expected = 1'b0;
        case (sel)
            FN_NOT_A:    expected = ~a;
            FN_NOR:      expected = ~(a | b);
            FN_AND:      expected = a & b;
            FN_OR:       expected = a | b;
            FN_XOR:      expected = a ^ b;
            FN_XNOR:     expected = ~(a ^ b);
            FN_NAND:     expected = ~(a & b);
            FN_NAND_ALT: expected = ~(a & b);
            default:     expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/nor_func_checker.sv
// Self-test sequencer: sweeps all 32 {sel,a,b} vectors and checks the unit's output.
// Optional build macro NOR_CHK_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module nor_func_checker
    import nor_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    nor_func_checker_if.master   bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $error("nor_func_checker: SETTLE_CYCLES must lie in 1..15");
    end

    state_t           r_state;
    state_t           w_next;
    logic [VEC_W-1:0] r_vec;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_err;
    logic [VEC_W-1:0] r_first;
    logic             r_have_fail;
    logic             r_pass;
    logic             r_busy;
    logic             r_done;
    logic             w_expected;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;

    nor_chk_golden u_golden (
        .sel      (r_vec[4:2]),
        .a        (r_vec[1]),
        .b        (r_vec[0]),
        .expected (w_expected)
    );

    assign w_mismatch = (r_state == ST_SAMPLE) && (bus.dut_out != w_expected);
    assign w_err_next = r_err + {{(CNT_W-1){1'b0}}, w_mismatch};

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_SETTLE;
                else           w_next = ST_IDLE;
            end
            ST_SETTLE: begin
                if (r_cnt == SETTLE_LAST) w_next = ST_SAMPLE;
                else                      w_next = ST_SETTLE;
            end
            ST_SAMPLE: begin
`ifdef NOR_CHK_STOP_ON_FAIL_EN
                if (w_mismatch || (r_vec == VEC_LAST)) w_next = ST_DONE;
                else                                   w_next = ST_SETTLE;
`else
                if (r_vec == VEC_LAST) w_next = ST_DONE;
                else                   w_next = ST_SETTLE;
`endif
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Vector/settle counters, result capture and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec       <= 5'd0;
            r_cnt       <= 4'd0;
            r_err       <= 6'd0;
            r_first     <= 5'd0;
            r_have_fail <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_SETTLE) || (w_next == ST_SAMPLE);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_vec       <= 5'd0;
                        r_cnt       <= 4'd0;
                        r_err       <= 6'd0;
                        r_first     <= 5'd0;
                        r_have_fail <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                ST_SETTLE: r_cnt <= r_cnt + 4'd1;
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_err <= w_err_next;
                        if (!r_have_fail) begin
                            r_first     <= r_vec;
                            r_have_fail <= 1'b1;
                        end
                    end
                    // pass must already reflect the final sample when done is shown
                    if (w_next == ST_DONE) begin
                        r_pass <= (w_err_next == 6'd0);
                    end else begin
                        r_vec <= r_vec + 5'd1;
                        r_cnt <= 4'd0;
                    end
                end
                ST_DONE: r_done <= 1'b0;
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.dut_sel    = r_vec[4:2];
    assign bus.dut_a      = r_vec[1];
    assign bus.dut_b      = r_vec[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_cnt    = r_err;
    assign bus.first_fail = r_first;

endmodule

// File: doc/nor_func_checker.md
# nor_func_checker

Self-test sequencer and checker for the 3-bit-select, 8-function NOR-gate logic unit: the initiator that drives the unit's `a`, `b` and `sel` inputs and reads back its `out`. On `start` it sweeps all 32 `{sel,a,b}` combinations, waits a settle interval per vector, and compares `out` against a golden model. It reports pass/fail, the error count and the first failing vector. It sits beside the unit on the lab board or in the bench, with results driven to LEDs.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `dut_out`  in  1  unit output under test.
- `dut_a`  out  1  unit input a.
- `dut_b`  out  1  unit input b.
- `dut_sel`  out  3  unit function select.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep ends.
- `pass`  out  1  last sweep had zero mismatches; held until the next start.
- `err_cnt`  out  6  mismatch count of the last sweep, range 0..32.
- `first_fail`  out  5  `{sel,a,b}` of the first mismatch; 0 if there was none.

## Operation
- Vector index `vec[4:0]`: `dut_sel=vec[4:2]`, `dut_a=vec[1]`, `dut_b=vec[0]`. All three outputs are registered.
- Golden function per sel:
  - 0: ~a
  - 1: ~(a|b)
  - 2: a&b
  - 3: a|b
  - 4: a^b
  - 5: ~(a^b)
  - 6: ~(a&b)
  - 7: ~(a&b)
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `busy=0`.
  - On `start=1`: `vec←0`, `err_cnt←0`, `first_fail←0`, `pass←0`, settle counter ←0, go to SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - After SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE (1 cycle):
  - Compare `dut_out` against golden(vec).
  - On mismatch: `err_cnt+1`; if this is the first mismatch, capture `first_fail←vec`.
  - If `vec==31`, go to DONE. Otherwise `vec+1`, clear the counter, go to SETTLE.
- DONE (1 cycle):
  - `done=1`, `busy=0`.
  - `pass←(err_cnt==0)`, including the final sample's result.
  - Return to IDLE.
- `start` is ignored outside IDLE. A `start` held high in IDLE launches a new sweep on every return to IDLE.
- `err_cnt` cannot overflow: 6 bits, maximum 32.

## Timing
- Reset values:
  - state IDLE
  - `dut_a=dut_b=0`, `dut_sel=0`
  - `busy=0`, `done=0`, `pass=0`
  - `err_cnt=0`, `first_fail=0`
- Call the edge that samples `start` T0. Vector 0 appears on `dut_*` immediately after T0.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- `done` is high for the single cycle after edge T0+32·(SETTLE_CYCLES+1). With the default this is the cycle after T0+96.
- `busy` is high from the cycle after T0 through the last SAMPLE cycle.
- `pass`, `err_cnt` and `first_fail` are valid from the `done` cycle and held until the next accepted `start`.
- `rst` asserted mid-sweep returns everything to reset values immediately (asynchronous). No `done` pulse is emitted.

## Configuration
- `NOR_CHK_STOP_ON_FAIL_EN` defined: a mismatch in SAMPLE goes directly to DONE. In that case `err_cnt=1` and `first_fail` is the failing vector. `dut_*` hold the failing vector until the next start, for debug.
- `NOR_CHK_STOP_ON_FAIL_EN` undefined: the full 32-vector sweep always runs and the behaviour is as above.

## Structure
- `nor_chk_pkg` contains:
  - state enum
  - function-code localparams for sel 0..7
  - vector width 5
  - count width 6
- Sub-module `nor_chk_golden`: combinational, `{sel,a,b}` → expected bit. It is instantiated once and is reusable by benches.
- Top-level holds:
  - FSM
  - vec and settle counters
  - result registers
- SETTLE_CYCLES outside 1..15 is flagged by an elaboration-time check.

## Test plan
- Correct behavioural unit, default parameter, pulse `start` → `done` in the cycle after T0+96; `pass=1`, `err_cnt=0`, `first_fail=0`.
- Unit with sel 5 computing `a|~b` → `pass=0`, `err_cnt=1`, `first_fail=5'b10110`. With `NOR_CHK_STOP_ON_FAIL_EN` defined: `done` arrives after vector 22 (cycle after T0+69); `dut_sel=5`, `dut_a=1`, `dut_b=0` held.
- `dut_out` stuck at 0 → `err_cnt=17`, `first_fail=0`, `pass=0`.
- `rst` pulsed while `vec=10` → all outputs return to 0 at once, no `done`. A new `start` sweeps from vector 0.
- `start` re-pulsed mid-sweep → ignored; a single `done` at the nominal cycle with unchanged results. With `SETTLE_CYCLES=1`: `done` in the cycle after T0+64.
